// File: rtl/row_extent_tracker.sv
// Row extent tracker: finds the first and last inked rows of a frame from the
// per-row "any pixel set" bit and holds {Top, Bottom, Empty} behind a
// valid/ready handshake.
// Optional feature: define ROW_EXTENT_INK_COUNT_EN to add the InkRows output.
module row_extent_tracker #(
    parameter int unsigned ROWS  = 28,
    parameter int unsigned IDX_W = 5
) (
    input  logic             GlobalClock,
    input  logic             Reset_n,
    input  logic             FrameStart,
    input  logic             RowValid,
    input  logic             RowAny,
    output logic             RowReady,
    output logic             ResultValid,
    input  logic             ResultReady,
    output logic [IDX_W-1:0] Top,
    output logic [IDX_W-1:0] Bottom,
    output logic             Empty
`ifdef ROW_EXTENT_INK_COUNT_EN
    ,
    output logic [IDX_W:0]   InkRows
`endif
);

    localparam int unsigned      CNT_W    = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] top_q, top_d;
    logic [IDX_W-1:0] bot_q, bot_d;
    logic             seen_q, seen_d;
    logic             empty_q, empty_d;
    logic             row_ready_q, row_ready_d;
    logic             res_valid_q, res_valid_d;
`ifdef ROW_EXTENT_INK_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic row_accept;
    logic seen_nxt;

    // A row is taken only while the block advertises readiness.
    assign row_accept = RowValid && row_ready_q;

    // State and result registers; reset discards any frame in progress.
    always_ff @(posedge GlobalClock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            top_q       <= '0;
            bot_q       <= '0;
            seen_q      <= 1'b0;
            empty_q     <= 1'b1;
            row_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
`ifdef ROW_EXTENT_INK_COUNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            top_q       <= top_d;
            bot_q       <= bot_d;
            seen_q      <= seen_d;
            empty_q     <= empty_d;
            row_ready_q <= row_ready_d;
            res_valid_q <= res_valid_d;
`ifdef ROW_EXTENT_INK_COUNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Next-state: frame start (also an abort in SCAN), row scan, result hold.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        top_d       = top_q;
        bot_d       = bot_q;
        seen_d      = seen_q;
        empty_d     = empty_q;
        row_ready_d = row_ready_q;
        res_valid_d = res_valid_q;
        seen_nxt    = seen_q;
`ifdef ROW_EXTENT_INK_COUNT_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            ST_IDLE, ST_SCAN: begin
                if (row_accept) begin
                    if (FrameStart) begin
                        // Row 0 of a new frame; any partial frame is dropped.
                        state_d = ST_SCAN;
                        idx_d   = IDX_W'(1);
                        seen_d  = RowAny;
                        if (RowAny) begin
                            top_d = '0;
                            bot_d = '0;
                        end
`ifdef ROW_EXTENT_INK_COUNT_EN
                        cnt_d = CNT_W'(RowAny);
`endif
                    end else if (state_q == ST_SCAN) begin
                        seen_nxt = seen_q | RowAny;
                        seen_d   = seen_nxt;
                        if (RowAny) begin
                            if (!seen_q) begin
                                top_d = idx_q;
                            end
                            bot_d = idx_q;
`ifdef ROW_EXTENT_INK_COUNT_EN
                            cnt_d = cnt_q + CNT_W'(1);
`endif
                        end
                        if (idx_q == LAST_IDX) begin
                            // Last row taken: publish the result next cycle.
                            state_d     = ST_HOLD;
                            row_ready_d = 1'b0;
                            res_valid_d = 1'b1;
                            empty_d     = ~seen_nxt;
                            if (!seen_nxt) begin
                                top_d = '0;
                                bot_d = '0;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (ResultReady) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                    row_ready_d = 1'b1;
                    idx_d       = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign RowReady    = row_ready_q;
    assign ResultValid = res_valid_q;
    assign Top         = top_q;
    assign Bottom      = bot_q;
    assign Empty       = empty_q;
`ifdef ROW_EXTENT_INK_COUNT_EN
    assign InkRows     = cnt_q;
`endif

endmodule

// File: tb/tb_row_extent_tracker.sv
// Bench for row_extent_tracker: directed scenarios plus random frames checked
// against a first/last-ink model computed directly from each frame's row bits.
module tb_row_extent_tracker;

    localparam int unsigned ROWS  = 28;
    localparam int unsigned IDX_W = 5;

    logic             clk;
    logic             rst_n;
    logic             frame_start;
    logic             row_valid;
    logic             row_any;
    logic             row_ready;
    logic             res_valid;
    logic             res_ready;
    logic [IDX_W-1:0] top;
    logic [IDX_W-1:0] bottom;
    logic             empty;
`ifdef ROW_EXTENT_INK_COUNT_EN
    logic [IDX_W:0]   ink_rows;
`endif

    int total;
    int bad;

    // Observed result vector: {ResultValid, RowReady, Empty, Top, Bottom}.
    logic [12:0] obs;
    assign obs = {res_valid, row_ready, empty, top, bottom};

    row_extent_tracker #(.ROWS(ROWS), .IDX_W(IDX_W)) dut (
        .GlobalClock (clk),
        .Reset_n     (rst_n),
        .FrameStart  (frame_start),
        .RowValid    (row_valid),
        .RowAny      (row_any),
        .RowReady    (row_ready),
        .ResultValid (res_valid),
        .ResultReady (res_ready),
        .Top         (top),
        .Bottom      (bottom),
        .Empty       (empty)
`ifdef ROW_EXTENT_INK_COUNT_EN
        ,
        .InkRows     (ink_rows)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected held result for a frame: first and last set bit, or empty.
    function automatic logic [12:0] model_exp(input logic [ROWS-1:0] f);
        int first;
        int last;
        first = -1;
        last  = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (f[i]) begin
                if (first < 0) first = i;
                last = i;
            end
        end
        if (first < 0) return {1'b1, 1'b0, 1'b1, 5'd0, 5'd0};
        return {1'b1, 1'b0, 1'b0, 5'(first), 5'(last)};
    endfunction

    function automatic logic [IDX_W:0] model_cnt(input logic [ROWS-1:0] f);
        return (IDX_W + 1)'($countones(f));
    endfunction

    function automatic logic [ROWS-1:0] rand_frame();
        logic [ROWS-1:0] f;
        int a;
        int b;
        f = '0;
        case ($urandom_range(0, 3))
            0: f = ROWS'({$urandom(), $urandom()});
            1: f = '0;
            2: f[$urandom_range(0, ROWS - 1)] = 1'b1;
            default: begin
                a = $urandom_range(0, ROWS - 1);
                b = $urandom_range(a, ROWS - 1);
                for (int i = a; i <= b; i++) f[i] = 1'b1;
            end
        endcase
        return f;
    endfunction

    // Sends one whole frame; returns #1 after the edge that takes the last row.
    task automatic drive_frame(input logic [ROWS-1:0] f, input int max_gap);
        for (int i = 0; i < ROWS; i++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    row_valid   = 1'b0;
                    frame_start = 1'($urandom_range(0, 1));
                    row_any     = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            row_valid   = 1'b1;
            frame_start = (i == 0);
            row_any     = f[i];
            @(posedge clk); #1;
        end
        row_valid   = 1'b0;
        frame_start = 1'b0;
        row_any     = 1'b0;
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        row_valid   = 1'b1;
        frame_start = 1'b1;
        row_any     = 1'b1;
        res_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs !== {1'b0, 1'b1, 1'b1, 5'd0, 5'd0}) begin
            bad++; $display("FAIL reset_values got=%h want=%h", obs, {1'b0, 1'b1, 1'b1, 5'd0, 5'd0});
        end
`ifdef ROW_EXTENT_INK_COUNT_EN
        total++;
        if (ink_rows !== '0) begin bad++; $display("FAIL reset_inkrows got=%0d want=0", ink_rows); end
`endif
        row_valid   = 1'b0;
        frame_start = 1'b0;
        row_any     = 1'b0;
        rst_n       = 1'b1;
        @(posedge clk); #1;
        total++;
        if (obs !== {1'b0, 1'b1, 1'b1, 5'd0, 5'd0}) begin
            bad++; $display("FAIL reset_idle got=%h want=%h", obs, {1'b0, 1'b1, 1'b1, 5'd0, 5'd0});
        end
    endtask

    task automatic test_ink_range();
        logic [ROWS-1:0] f;
        f = '0;
        for (int i = 5; i <= 20; i++) f[i] = 1'b1;
        drive_frame(f, 0);
        total++;
        if (obs !== {1'b1, 1'b0, 1'b0, 5'd5, 5'd20}) begin
            bad++; $display("FAIL ink_5_20 got=%h want=%h", obs, {1'b1, 1'b0, 1'b0, 5'd5, 5'd20});
        end
`ifdef ROW_EXTENT_INK_COUNT_EN
        total++;
        if (ink_rows !== 6'd16) begin bad++; $display("FAIL ink_5_20_count got=%0d want=16", ink_rows); end
`endif
        release_result();
    endtask

    task automatic test_empty();
        drive_frame('0, 1);
        total++;
        if (obs !== {1'b1, 1'b0, 1'b1, 5'd0, 5'd0}) begin
            bad++; $display("FAIL empty_frame got=%h want=%h", obs, {1'b1, 1'b0, 1'b1, 5'd0, 5'd0});
        end
`ifdef ROW_EXTENT_INK_COUNT_EN
        total++;
        if (ink_rows !== '0) begin bad++; $display("FAIL empty_count got=%0d want=0", ink_rows); end
`endif
        release_result();
    endtask

    task automatic test_hold_stall();
        logic [ROWS-1:0] f;
        logic [12:0]     exp;
        f = '0;
        f[7] = 1'b1;
        f[18] = 1'b1;
        exp = model_exp(f);
        drive_frame(f, 1);
        for (int c = 0; c < 10; c++) begin
            res_ready   = 1'b0;
            row_valid   = 1'($urandom_range(0, 1));
            frame_start = 1'($urandom_range(0, 1));
            row_any     = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            total++;
            if (obs !== exp) begin bad++; $display("FAIL hold_stable c=%0d got=%h want=%h", c, obs, exp); end
        end
        // Handshake with a competing FrameStart that must not be taken.
        res_ready   = 1'b1;
        row_valid   = 1'b1;
        frame_start = 1'b1;
        row_any     = 1'b1;
        @(posedge clk); #1;
        res_ready   = 1'b0;
        row_valid   = 1'b0;
        frame_start = 1'b0;
        total++;
        if ({res_valid, row_ready} !== 2'b01) begin
            bad++; $display("FAIL hold_release got=%b want=01", {res_valid, row_ready});
        end
        // In IDLE, 27 rows without FrameStart must not complete a frame.
        repeat (ROWS - 1) begin
            row_valid = 1'b1;
            row_any   = 1'b1;
            @(posedge clk); #1;
        end
        row_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({res_valid, row_ready} !== 2'b01) begin
            bad++; $display("FAIL handshake_fs_ignored got=%b want=01", {res_valid, row_ready});
        end
    endtask

    task automatic test_abort();
        logic [ROWS-1:0] f;
        for (int i = 0; i < 12; i++) begin
            row_valid   = 1'b1;
            frame_start = (i == 0);
            row_any     = (i == 3);
            @(posedge clk); #1;
        end
        f = '0;
        f[ROWS-1] = 1'b1;
        drive_frame(f, 0);
        total++;
        if (obs !== {1'b1, 1'b0, 1'b0, 5'd27, 5'd27}) begin
            bad++; $display("FAIL abort_row27 got=%h want=%h", obs, {1'b1, 1'b0, 1'b0, 5'd27, 5'd27});
        end
`ifdef ROW_EXTENT_INK_COUNT_EN
        total++;
        if (ink_rows !== 6'd1) begin bad++; $display("FAIL abort_count got=%0d want=1", ink_rows); end
`endif
        release_result();
    endtask

    task automatic test_reset_mid_scan();
        logic [ROWS-1:0] f;
        logic [12:0]     exp;
        for (int i = 0; i < 10; i++) begin
            row_valid   = 1'b1;
            frame_start = (i == 0);
            row_any     = (i >= 2);
            @(posedge clk); #1;
        end
        // Row 10 on the wire when reset hits mid-cycle.
        row_valid = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== {1'b0, 1'b1, 1'b1, 5'd0, 5'd0}) begin
            bad++; $display("FAIL async_reset got=%h want=%h", obs, {1'b0, 1'b1, 1'b1, 5'd0, 5'd0});
        end
        row_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (ROWS + 2) begin
            row_valid   = 1'b1;
            frame_start = 1'b0;
            row_any     = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        row_valid = 1'b0;
        total++;
        if ({res_valid, row_ready} !== 2'b01) begin
            bad++; $display("FAIL post_reset_ignored got=%b want=01", {res_valid, row_ready});
        end
        f = rand_frame();
        f[9] = 1'b1;
        exp = model_exp(f);
        drive_frame(f, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL post_reset_frame got=%h want=%h", obs, exp); end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [ROWS-1:0] f;
        logic [12:0]     exp;
        for (int k = 0; k < 3; k++) begin
            f = (k == 0) ? ROWS'(1) : (k == 1) ? {1'b1, {(ROWS - 1){1'b0}}} : '1;
            exp = model_exp(f);
            drive_frame(f, 0);
            total++;
            if (obs !== exp) begin bad++; $display("FAIL b2b k=%0d got=%h want=%h", k, obs, exp); end
`ifdef ROW_EXTENT_INK_COUNT_EN
            total++;
            if (ink_rows !== model_cnt(f)) begin
                bad++; $display("FAIL b2b_count k=%0d got=%0d want=%0d", k, ink_rows, model_cnt(f));
            end
`endif
            release_result();
        end
    endtask

    task automatic test_random();
        logic [ROWS-1:0] f;
        logic [12:0]     exp;
        for (int n = 0; n < 20; n++) begin
            f   = rand_frame();
            exp = model_exp(f);
            drive_frame(f, 2);
            total++;
            if (obs !== exp) begin bad++; $display("FAIL rand n=%0d f=%h got=%h want=%h", n, f, obs, exp); end
`ifdef ROW_EXTENT_INK_COUNT_EN
            total++;
            if (ink_rows !== model_cnt(f)) begin
                bad++; $display("FAIL rand_count n=%0d got=%0d want=%0d", n, ink_rows, model_cnt(f));
            end
`endif
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            release_result();
            total++;
            if ({res_valid, row_ready} !== 2'b01) begin
                bad++; $display("FAIL rand_release n=%0d got=%b want=01", n, {res_valid, row_ready});
            end
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        row_valid   = 1'b0;
        frame_start = 1'b0;
        row_any     = 1'b0;
        res_ready   = 1'b0;
        test_reset();
        test_ink_range();
        test_empty();
        test_hold_stall();
        test_abort();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
